// File: rtl/gf_clmul_sched_pkg.sv
// Shared definitions for the carry-less multiply scheduler: word width,
// FSM state encoding and a plain 8x8 carry-less product function.
package gf_clmul_pkg;

   localparam int W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   // 8x8 carry-less product, 15 significant bits
   function automatic logic [2*W-2:0] clmul8(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-2:0] p;
      p = '0;
      for (int k = 0; k < W; k++)
         if (b[k]) p = p ^ ((2*W-1)'(a) << k);
      return p;
   endfunction

endpackage

// File: rtl/gf_clmul_sched_if.sv
// Request/result bundle of the shared carry-less multiplier.
// master = requester/consumer side, slave = scheduler side.
interface gf_clmul_sched_if
   import gf_clmul_pkg::*;
#(
   parameter int NW = 4
);
   logic [1:0]          in_valid;
   logic [1:0]          in_ready;
   logic [W*NW-1:0]     in_a0;
   logic [W*NW-1:0]     in_b0;
   logic [W*NW-1:0]     in_a1;
   logic [W*NW-1:0]     in_b1;
   logic                out_valid;
   logic                out_ready;
   logic                out_id;
   logic [2*W*NW-1:0]   out_p;
   logic                busy;

   modport master (
      output in_valid, in_a0, in_b0, in_a1, in_b1, out_ready,
      input  in_ready, out_valid, out_id, out_p, busy
   );

   modport slave (
      input  in_valid, in_a0, in_b0, in_a1, in_b1, out_ready,
      output in_ready, out_valid, out_id, out_p, busy
   );
endinterface

// File: rtl/gf_clmul_sched_core.sv
// Combinational 8x8 carry-less multiplier. The product sits in c[15:1],
// c[0] is always 0.
module gf8_clmul_core
   import gf_clmul_pkg::*;
(
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] c
);
   logic [2*W-2:0] p;

   // shift-and-XOR: every set bit of b adds a shifted copy of a
   always_comb begin
      p = '0;
      for (int k = 0; k < W; k++)
         if (b[k]) p = p ^ ((2*W-1)'(a) << k);
      c = {p, 1'b0};
   end
endmodule

// File: rtl/gf_clmul_sched.sv
// Round-robin scheduler sharing one 8x8 carry-less core between two
// requesters; produces the unreduced 16*NW-bit product word pair by pair.
// Optional build macro GF_CLMUL_SCHED_ZERO_SKIP_EN: word pairs with a zero
// word are skipped and take no cycle.
module gf_clmul_sched
   import gf_clmul_pkg::*;
#(
   parameter int NW = 4
)
(
   input  logic            clk,
   input  logic            rst_n,
   gf_clmul_sched_if.slave bus
);
   localparam int OP_W  = W * NW;
   localparam int ACC_W = 2 * W * NW;
   localparam int NP    = NW * NW;
   localparam int CW    = (NP > 1) ? $clog2(NP) : 1;
   localparam int SW    = $clog2(2 * NW) + 1;
`ifdef GF_CLMUL_SCHED_ZERO_SKIP_EN
   localparam bit SKIP_EN = 1'b1;
`else
   localparam bit SKIP_EN = 1'b0;
`endif

   state_t            state, state_nxt;
   logic              rr_last;
   logic [CW-1:0]     cnt;
   logic              issue_q;
   logic              vld_p1;
   logic [2*W-1:0]    prod_p1;
   logic [SW-1:0]     sh_p1;
   logic [OP_W-1:0]   a_q, b_q;
   logic              id_q;
   logic [ACC_W-1:0]  acc;

   logic [1:0]        grant;
   logic              gnt_id, accept;
   logic [OP_W-1:0]   a_sel, b_sel;
   logic [CW:0]       first_pair, next_pair;
   logic [W-1:0]      wa, wb;
   logic [2*W-1:0]    core_c;
   int                ii, jj;

   // a pair needs a cycle unless skipping is enabled and one of its words is zero
   function automatic logic pair_ok(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                    input int k);
      logic nz;
      nz = (a[W*(k/NW) +: W] != '0) && (b[W*(k%NW) +: W] != '0);
      return !SKIP_EN || nz;
   endfunction

   // {found, index} of the first usable pair at or after start
   function automatic logic [CW:0] find_pair(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                             input int start);
      logic [CW:0] r;
      r = '0;
      for (int k = NP - 1; k >= 0; k--)
         if (k >= start && pair_ok(a, b, k)) r = {1'b1, CW'(k)};
      return r;
   endfunction

   // arbiter: only in IDLE and out of reset; ties go to the requester not served last
   always_comb begin
      grant = 2'b00;
      if (state == IDLE && rst_n) begin
         case (bus.in_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   assign bus.in_ready = grant;
   assign accept       = |(bus.in_valid & grant);
   assign gnt_id       = grant[1];
   assign a_sel        = gnt_id ? bus.in_a1 : bus.in_a0;
   assign b_sel        = gnt_id ? bus.in_b1 : bus.in_b0;
   assign first_pair   = find_pair(a_sel, b_sel, 0);
   assign next_pair    = find_pair(a_q, b_q, int'(cnt) + 1);

   // pair index -> A word i (outer), B word j (inner)
   always_comb begin
      ii = int'(cnt) / NW;
      jj = int'(cnt) % NW;
      wa = a_q[W*ii +: W];
      wb = b_q[W*jj +: W];
   end

   gf8_clmul_core u_core (
      .a (wa),
      .b (wb),
      .c (core_c)
   );

   // control state: FSM, round-robin pointer, pair counter, stage-1 valid
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         rr_last <= 1'b1;
         cnt     <= '0;
         issue_q <= 1'b0;
         vld_p1  <= 1'b0;
      end else begin
         state  <= state_nxt;
         vld_p1 <= 1'b0;
         if (accept) begin
            rr_last <= gnt_id;
            cnt     <= first_pair[CW-1:0];
            issue_q <= first_pair[CW];
         end else if (state == MUL && issue_q) begin
            vld_p1  <= 1'b1;
            cnt     <= next_pair[CW-1:0];
            issue_q <= next_pair[CW];
         end
      end
   end

   // --- stage 0 -> 1: core product and word offset registered ---
   // --- stage 1: XOR-accumulate; c[0] is zero, so shifting the whole core
   //     word and dropping one bit lands c[15:1] at the word offset ---
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q  <= a_sel;
         b_q  <= b_sel;
         id_q <= gnt_id;
         acc  <= '0;
      end else if (state == MUL) begin
         if (issue_q) begin
            prod_p1 <= core_c;
            sh_p1   <= SW'(ii + jj);
         end
         if (vld_p1)
            acc <= acc ^ ((ACC_W'(prod_p1) << (W * int'(sh_p1))) >> 1);
      end
   end

   // next state and outputs; results only visible in DONE
   always_comb begin
      state_nxt     = state;
      bus.out_valid = 1'b0;
      bus.out_p     = '0;
      bus.out_id    = 1'b0;
      bus.busy      = (state != IDLE);
      case (state)
         IDLE: if (accept) state_nxt = MUL;
         MUL:  if (!issue_q) state_nxt = DONE;
         DONE: begin
            bus.out_valid = 1'b1;
            bus.out_p     = acc;
            bus.out_id    = id_q;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_gf_clmul_sched.sv
// Directed bench for gf_clmul_sched (NW=4): vector table plus sequences for
// arbitration, output back-pressure and mid-operation reset.
module tb_gf_clmul_sched;
   localparam int NW = 4;
`ifdef GF_CLMUL_SCHED_ZERO_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   gf_clmul_sched_if #(.NW(NW)) bus ();

   gf_clmul_sched #(.NW(NW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      bit          id;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p;
      int          lat_full;
      int          lat_skip;
   } vec_t;

   vec_t        vecs[10];
   int          checks = 0;
   int          failures = 0;
   logic [63:0] got_p;
   logic        got_id;
   int          got_lat;
   int          onehot_bad, ngr, nouts, seen;
   bit          gr[4];
   logic        oid[4];
   logic [63:0] op[4];
   logic [63:0] hold_p;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.in_valid  = 2'b00;
      bus.out_ready = 1'b0;
      bus.in_a0 = '0; bus.in_b0 = '0;
      bus.in_a1 = '0; bus.in_b1 = '0;
   endtask

   // present a request, wait for the grant, drop valid after the accepting edge
   task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b);
      int w;
      if (id) begin bus.in_a1 = a; bus.in_b1 = b; end
      else    begin bus.in_a0 = a; bus.in_b0 = b; end
      bus.in_valid[id] = 1'b1;
      #1;
      w = 0;
      while (!bus.in_ready[id] && w < 60) begin
         @(negedge clk);
         w++;
      end
      chk("accept_timeout", 64'(w < 60), 64'd1);
      @(negedge clk);
      bus.in_valid[id] = 1'b0;
   endtask

   // count edges after the accept until out_valid is seen
   task automatic wait_out(output logic [63:0] p, output logic id, output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      p  = bus.out_p;
      id = bus.out_id;
   endtask

   task automatic out_hs();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b0, 32'h0000_0003, 32'h0000_0003, 64'h5,                  17, 2};
      vecs[1] = '{1'b0, 32'h0000_0080, 32'h0000_0080, 64'h4000,               17, 2};
      vecs[2] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h5555_5555_5555_5555, 17, 17};
      vecs[3] = '{1'b1, 32'h0000_0100, 32'h0000_0100, 64'h1_0000,             17, 2};
      vecs[4] = '{1'b0, 32'h0000_0001, 32'h0100_0000, 64'h0100_0000,          17, 2};
      vecs[5] = '{1'b0, 32'h0000_00FF, 32'h0000_00FF, 64'h5555,               17, 2};
      vecs[6] = '{1'b1, 32'h0101_0101, 32'h0000_0001, 64'h0101_0101,          17, 5};
      vecs[7] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 17, 2};
      vecs[8] = '{1'b1, 32'h0000_0000, 32'h1234_5678, 64'h0,                  17, 1};
      vecs[9] = '{1'b0, 32'h0000_0003, 32'h0000_0300, 64'h500,                17, 2};

      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_id",    64'(bus.out_id),    64'd0);
      chk("rst_out_p",     bus.out_p,          64'd0);
      chk("rst_busy",      64'(bus.busy),      64'd0);

      // both requesters held valid from reset: grants alternate starting at 0
      bus.in_a0 = 32'h3;   bus.in_b0 = 32'h3;
      bus.in_a1 = 32'h100; bus.in_b1 = 32'h100;
      bus.in_valid  = 2'b11;
      bus.out_ready = 1'b1;
      #1;
      onehot_bad = 0; ngr = 0; nouts = 0;
      for (int c = 0; c < 200 && nouts < 4; c++) begin
         if (!(bus.in_ready inside {2'b00, 2'b01, 2'b10})) onehot_bad++;
         if (bus.in_ready != 2'b00 && ngr < 4) begin
            gr[ngr] = bus.in_ready[1];
            ngr++;
         end
         if (bus.out_valid) begin
            oid[nouts] = bus.out_id;
            op[nouts]  = bus.out_p;
            nouts++;
         end
         @(negedge clk);
      end
      bus.in_valid  = 2'b00;
      bus.out_ready = 1'b0;
      chk("rr_onehot_violations", 64'(onehot_bad), 64'd0);
      chk("rr_output_count",      64'(nouts),      64'd4);
      for (int k = 0; k < 4 && k < nouts; k++) begin
         chk($sformatf("rr_grant%0d", k),  64'(gr[k]),  64'(k % 2));
         chk($sformatf("rr_out_id%0d", k), 64'(oid[k]), 64'(gr[k]));
         chk($sformatf("rr_out_p%0d", k),  op[k], (k % 2) ? 64'h1_0000 : 64'h5);
      end
      @(negedge clk);

      // vector table
      for (int v = 0; v < 10; v++) begin
         issue(vecs[v].id, vecs[v].a, vecs[v].b);
         wait_out(got_p, got_id, got_lat);
         chk($sformatf("vec%0d_p", v),   got_p,         vecs[v].p);
         chk($sformatf("vec%0d_id", v),  64'(got_id),   64'(vecs[v].id));
         chk($sformatf("vec%0d_lat", v), 64'(got_lat),
             64'(SKIP ? vecs[v].lat_skip : vecs[v].lat_full));
         out_hs();
      end

      // back-pressure in DONE while requester 1 waits
      issue(1'b0, 32'hFF, 32'hFF);
      wait_out(got_p, got_id, got_lat);
      hold_p = got_p;
      chk("bp_first_p", got_p, 64'h5555);
      bus.in_a1 = 32'h100; bus.in_b1 = 32'h100;
      bus.in_valid[1] = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp%0d_out_valid", k), 64'(bus.out_valid), 64'd1);
         chk($sformatf("bp%0d_out_p", k),     bus.out_p,          hold_p);
         chk($sformatf("bp%0d_out_id", k),    64'(bus.out_id),    64'd0);
         chk($sformatf("bp%0d_in_ready", k),  64'(bus.in_ready),  64'd0);
         chk($sformatf("bp%0d_busy", k),      64'(bus.busy),      64'd1);
         @(negedge clk);
      end
      out_hs();
      chk("bp_accept_after_out", 64'(bus.in_ready), 64'h2);
      chk("bp_idle_busy",        64'(bus.busy),     64'd0);
      @(negedge clk);
      bus.in_valid = 2'b00;
      wait_out(got_p, got_id, got_lat);
      chk("bp_second_p",   got_p,        64'h1_0000);
      chk("bp_second_id",  64'(got_id),  64'd1);
      chk("bp_second_lat", 64'(got_lat), SKIP ? 64'd2 : 64'd17);
      out_hs();

      // reset in the middle of MUL aborts the request
      issue(1'b0, 32'h3, 32'h3);
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("abort_in_ready",  64'(bus.in_ready),  64'd0);
      chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
      chk("abort_out_id",    64'(bus.out_id),    64'd0);
      chk("abort_out_p",     bus.out_p,          64'd0);
      chk("abort_busy",      64'(bus.busy),      64'd0);
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      chk("abort_no_output", 64'(seen), 64'd0);
      issue(1'b1, 32'h100, 32'h100);
      wait_out(got_p, got_id, got_lat);
      chk("abort_next_p",   got_p,        64'h1_0000);
      chk("abort_next_id",  64'(got_id),  64'd1);
      chk("abort_next_lat", 64'(got_lat), SKIP ? 64'd2 : 64'd17);
      out_hs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
